// File: rtl/locked_reg_read_port.sv
// rtl/locked_reg_read_port.sv - lock-aware read responder for a bank of configuration registers
// Optional feature macro: READ_AUDIT_EN adds the denial audit record (audit_flag/audit_addr/audit_clr).
module locked_reg_read_port #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 8
) (
    input  logic                       Clk,
    input  logic                       resetn,
    input  logic [DATA_W*NUM_REGS-1:0] reg_data,
    input  logic [NUM_REGS-1:0]        reg_lock,
    input  logic                       debug_mode,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_trusted,
    output logic                       rd_rsp_valid,
    input  logic                       rd_rsp_ready,
    output logic [DATA_W-1:0]          rd_rsp_data,
    output logic                       rd_rsp_err,
    output logic [CNT_W-1:0]           deny_cnt
`ifdef READ_AUDIT_EN
    ,
    input  logic                       audit_clr,
    output logic                       audit_flag,
    output logic [ADDR_W-1:0]          audit_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                trusted_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic [CNT_W-1:0]    deny_cnt_q;

    logic                in_range;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_lock;
    logic                deny;

    // debug_mode is deliberately ignored: it must never open a locked register.
    logic unused_debug_mode;
    assign unused_debug_mode = debug_mode;

    assign in_range = (32'(addr_q) < NUM_REGS);

    // Select the addressed register and its lock without indexing past the bank.
    always_comb begin
        sel_data = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel_data = reg_data[i*DATA_W +: DATA_W];
                sel_lock = reg_lock[i];
            end
        end
    end

    // Out-of-range is checked first; otherwise a lock blocks untrusted requesters.
    assign deny = !in_range || (sel_lock && !trusted_q);

    // Request/check/response sequencer with registered response outputs.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            trusted_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            deny_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req_valid) begin
                        addr_q    <= rd_addr;
                        trusted_q <= rd_trusted;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    if (deny) begin
                        rsp_err_q  <= 1'b1;
                        rsp_data_q <= '0;
                        if (deny_cnt_q != {CNT_W{1'b1}}) begin
                            deny_cnt_q <= deny_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        rsp_err_q  <= 1'b0;
                        rsp_data_q <= sel_data;
                    end
                end
                RESP: begin
                    if (rd_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready is gated by resetn so it stays low for the whole reset interval.
    assign rd_req_ready = (state_q == IDLE) && resetn;
    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = rsp_data_q;
    assign rd_rsp_err   = rsp_err_q;
    assign deny_cnt     = deny_cnt_q;

`ifdef READ_AUDIT_EN
    logic              audit_flag_q;
    logic [ADDR_W-1:0] audit_addr_q;

    // Record the most recent denial; a denial in the same cycle beats a clear.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            audit_flag_q <= 1'b0;
            audit_addr_q <= '0;
        end else if (state_q == CHECK && deny) begin
            audit_flag_q <= 1'b1;
            audit_addr_q <= addr_q;
        end else if (audit_clr) begin
            audit_flag_q <= 1'b0;
            audit_addr_q <= '0;
        end
    end

    assign audit_flag = audit_flag_q;
    assign audit_addr = audit_addr_q;
`else
    // Without the audit feature no denial record is kept.
`endif

endmodule

// File: tb/tb_locked_reg_read_port.sv
// tb/tb_locked_reg_read_port.sv - randomized self-checking bench for locked_reg_read_port
module tb_locked_reg_read_port;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;
    localparam int CNT_W    = 8;

    logic                       Clk;
    logic                       resetn;
    logic [DATA_W*NUM_REGS-1:0] reg_data;
    logic [NUM_REGS-1:0]        reg_lock;
    logic                       debug_mode;
    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [ADDR_W-1:0]          rd_addr;
    logic                       rd_trusted;
    logic                       rd_rsp_valid;
    logic                       rd_rsp_ready;
    logic [DATA_W-1:0]          rd_rsp_data;
    logic                       rd_rsp_err;
    logic [CNT_W-1:0]           deny_cnt;
`ifdef READ_AUDIT_EN
    logic                       audit_clr;
    logic                       audit_flag;
    logic [ADDR_W-1:0]          audit_addr;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              lk   [NUM_REGS];
    int                exp_cnt;
    int                n_checks;
    int                n_pass;

    locked_reg_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .resetn(resetn), .reg_data(reg_data), .reg_lock(reg_lock),
        .debug_mode(debug_mode), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_addr(rd_addr), .rd_trusted(rd_trusted), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
        .deny_cnt(deny_cnt)
`ifdef READ_AUDIT_EN
        , .audit_clr(audit_clr), .audit_flag(audit_flag), .audit_addr(audit_addr)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        reg_data = '0;
        reg_lock = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_data[i*DATA_W +: DATA_W] = regs[i];
            reg_lock[i] = lk[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full read; the expected response comes from the access rules applied to
    // the bench's own register/lock arrays as they stand in the check cycle.
    task automatic do_read(input int a, input bit t, input int hold, input bit flip);
        bit              exp_err;
        logic [15:0]     exp_data;
        logic [15:0]     seen_data;
        logic            seen_err;
        rd_addr      = a[ADDR_W-1:0];
        rd_trusted   = t;
        rd_req_valid = 1'b1;
        check("req_ready_idle", rd_req_ready, 1);
        @(posedge Clk); #1;
        rd_req_valid = 1'b0;
        rd_trusted   = ~t;
        if (flip && a < NUM_REGS) lk[a] = 1'b1;
        check("ready_in_check", rd_req_ready, 0);
        check("valid_in_check", rd_rsp_valid, 0);
        if (a >= NUM_REGS) exp_err = 1'b1;
        else exp_err = lk[a] && !t;
        exp_data = (exp_err || a >= NUM_REGS) ? 16'h0 : regs[a];
        if (exp_err) exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
        @(posedge Clk); #1;
        check("rsp_valid", rd_rsp_valid, 1);
        check("rsp_data", rd_rsp_data, exp_data);
        check("rsp_err", rd_rsp_err, exp_err);
        check("deny_cnt", deny_cnt, exp_cnt);
        seen_data = rd_rsp_data;
        seen_err  = rd_rsp_err;
        for (int h = 0; h < hold; h++) begin
            rd_req_valid = 1'b1;
            rd_addr      = ADDR_W'($urandom_range(0, 7));
            @(posedge Clk); #1;
            check("hold_valid", rd_rsp_valid, 1);
            check("hold_data", rd_rsp_data, seen_data);
            check("hold_err", rd_rsp_err, seen_err);
            check("hold_ready", rd_req_ready, 0);
        end
        rd_req_valid = 1'b0;
        rd_rsp_ready = 1'b1;
        @(posedge Clk); #1;
        rd_rsp_ready = 1'b0;
        check("post_valid", rd_rsp_valid, 0);
        check("post_ready", rd_req_ready, 1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; exp_cnt = 0;
        resetn = 1'b0; debug_mode = 1'b0; rd_req_valid = 1'b0; rd_addr = '0;
        rd_trusted = 1'b0; rd_rsp_ready = 1'b0;
`ifdef READ_AUDIT_EN
        audit_clr = 1'b0;
`endif
        for (int i = 0; i < NUM_REGS; i++) begin regs[i] = 16'(i * 16'h1111); lk[i] = 1'b0; end
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ready", rd_req_ready, 0);
        check("rst_valid", rd_rsp_valid, 0);
        check("rst_data", rd_rsp_data, 0);
        check("rst_err", rd_rsp_err, 0);
        check("rst_cnt", deny_cnt, 0);
        resetn = 1'b1;
        @(posedge Clk); #1;
        check("ready_after_rst", rd_req_ready, 1);

        // Unlocked register, untrusted requester.
        regs[2] = 16'hA5A5;
        do_read(2, 0, 0, 0);
        // Locked register with debug_mode asserted, then trusted.
        regs[5] = 16'h1234; lk[5] = 1'b1; debug_mode = 1'b1;
        do_read(5, 0, 0, 0);
        do_read(5, 1, 0, 0);
        debug_mode = 1'b0;
        // Out-of-range addresses.
        do_read(7, 1, 0, 0);
        do_read(6, 0, 0, 0);
        // Back-pressure held for 5 cycles.
        do_read(3, 0, 5, 0);
        // Lock set after acceptance must still deny.
        lk[1] = 1'b0; regs[1] = 16'hBEEF;
        do_read(1, 0, 0, 1);

        for (int n = 0; n < 120; n++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] = 16'($urandom);
                lk[i]   = 1'($urandom_range(0, 1));
            end
            debug_mode = 1'($urandom_range(0, 1));
            do_read($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
        end

        // Saturation of the denial counter.
        for (int n = 0; n < 260; n++) do_read(7, 0, 0, 0);
        check("cnt_saturated", deny_cnt, 255);
        do_read(7, 0, 0, 0);
        check("cnt_stays_sat", deny_cnt, 255);

        // Reset during the check cycle drops the request.
        rd_addr = 3'd0; rd_trusted = 1'b1; rd_req_valid = 1'b1;
        @(posedge Clk); #1;
        rd_req_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_valid", rd_rsp_valid, 0);
        check("midrst_ready", rd_req_ready, 0);
        check("midrst_data", rd_rsp_data, 0);
        check("midrst_err", rd_rsp_err, 0);
        check("midrst_cnt", deny_cnt, 0);
        exp_cnt = 0;
        repeat (2) @(posedge Clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("no_stale_rsp", rd_rsp_valid, 0);
        lk[0] = 1'b0; regs[0] = 16'h0F0F;
        do_read(0, 0, 1, 0);

`ifdef READ_AUDIT_EN
        check("audit_rst_flag", audit_flag, 0);
        lk[5] = 1'b1;
        do_read(5, 0, 0, 0);
        check("audit_flag", audit_flag, 1);
        check("audit_addr", audit_addr, 5);
        audit_clr = 1'b1;
        @(posedge Clk); #1;
        audit_clr = 1'b0;
        check("audit_clr_flag", audit_flag, 0);
        check("audit_clr_addr", audit_addr, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
